// File: rtl/reorder_buffer_if.sv
// Issue, operand-query, CDB and commit signals of the reorder buffer.
// The ROB itself attaches through the slave modport.
interface reorder_buffer_if #(
  parameter int ROB_ADDR_W = 4,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  alloc_valid;
  logic [REG_ADDR_W-1:0] alloc_rd;
  logic                  alloc_is_branch;
  logic                  alloc_pred_taken;
  logic                  alloc_ready;
  logic [ROB_ADDR_W-1:0] alloc_rob_num;

  logic [ROB_ADDR_W-1:0] q1_rob_num;
  logic [ROB_ADDR_W-1:0] q2_rob_num;
  logic                  q1_ready;
  logic                  q2_ready;
  logic [XLEN-1:0]       q1_data;
  logic [XLEN-1:0]       q2_data;

  logic                  cdb_valid;
  logic [ROB_ADDR_W-1:0] cdb_rob_num;
  logic [XLEN-1:0]       cdb_data;
  logic                  cdb_taken;
  logic [XLEN-1:0]       cdb_target;

  logic                  has_from_rob;
  logic [REG_ADDR_W-1:0] dest_reg_num;
  logic [XLEN-1:0]       in_reg_data;
  logic [ROB_ADDR_W-1:0] in_reg_rob_num;
  logic                  has_misbranch;
  logic [XLEN-1:0]       misbranch_pc;
  logic                  rob_empty;

  modport slave (
    input  alloc_valid, alloc_rd, alloc_is_branch, alloc_pred_taken,
    input  q1_rob_num, q2_rob_num,
    input  cdb_valid, cdb_rob_num, cdb_data, cdb_taken, cdb_target,
    output alloc_ready, alloc_rob_num, q1_ready, q2_ready, q1_data, q2_data,
    output has_from_rob, dest_reg_num, in_reg_data, in_reg_rob_num,
    output has_misbranch, misbranch_pc, rob_empty
  );

  modport master (
    output alloc_valid, alloc_rd, alloc_is_branch, alloc_pred_taken,
    output q1_rob_num, q2_rob_num,
    output cdb_valid, cdb_rob_num, cdb_data, cdb_taken, cdb_target,
    input  alloc_ready, alloc_rob_num, q1_ready, q2_ready, q1_data, q2_data,
    input  has_from_rob, dest_reg_num, in_reg_data, in_reg_rob_num,
    input  has_misbranch, misbranch_pc, rob_empty
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at the tail, captures CDB results,
// retires from the head into the register file and flushes on a mispredicted branch.
module reorder_buffer #(
  parameter int ROB_DEPTH  = 16,
  parameter int ROB_ADDR_W = 4,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  reorder_buffer_if.slave rob
);
  localparam logic [0:0]            ST_NORMAL = 1'b0;
  localparam logic [0:0]            ST_FLUSH  = 1'b1;
  localparam logic [ROB_ADDR_W:0]   FULL_CNT  = (ROB_ADDR_W + 1)'(ROB_DEPTH);
  localparam logic [ROB_ADDR_W:0]   CNT_ZERO  = {(ROB_ADDR_W + 1){1'b0}};
  localparam logic [ROB_ADDR_W:0]   CNT_ONE   = (ROB_ADDR_W + 1)'(1'b1);
  localparam logic [ROB_ADDR_W-1:0] PTR_ZERO  = {ROB_ADDR_W{1'b0}};
  localparam logic [ROB_ADDR_W-1:0] PTR_ONE   = ROB_ADDR_W'(1'b1);
  localparam logic [ROB_DEPTH-1:0]  VEC_ZERO  = {ROB_DEPTH{1'b0}};
  localparam logic [XLEN-1:0]       DATA_ZERO = {XLEN{1'b0}};
  localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};

  logic [ROB_DEPTH-1:0]  busy_q, busy_d, ready_q, ready_d;
  logic [ROB_DEPTH-1:0]  is_br_q, pred_q, taken_q;
  logic [REG_ADDR_W-1:0] rd_q     [ROB_DEPTH];
  logic [XLEN-1:0]       data_q   [ROB_DEPTH];
  logic [XLEN-1:0]       target_q [ROB_DEPTH];

  logic [ROB_ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_ADDR_W:0]   count_q, count_d;
  logic [0:0]            state_q, state_d;

  logic                  has_from_rob_q, has_from_rob_d;
  logic [REG_ADDR_W-1:0] dest_reg_num_q, dest_reg_num_d;
  logic [XLEN-1:0]       in_reg_data_q, in_reg_data_d;
  logic [ROB_ADDR_W-1:0] in_reg_rob_num_q, in_reg_rob_num_d;
  logic                  has_misbranch_q, has_misbranch_d;
  logic [XLEN-1:0]       misbranch_pc_q, misbranch_pc_d;

  logic                  normal_s, alloc_ready_s, do_alloc_s, cdb_wr_s, do_commit_s, mispredict_s;
  logic                  q1_ready_s, q2_ready_s;
  logic [XLEN-1:0]       q1_data_s, q2_data_s;

  // No full-bypass: a commit on the same edge does not free a slot for allocation.
  assign normal_s      = (state_q == ST_NORMAL);
  assign alloc_ready_s = normal_s && (count_q < FULL_CNT);
  assign do_alloc_s    = rob.alloc_valid && alloc_ready_s;
  assign cdb_wr_s      = normal_s && rob.cdb_valid && busy_q[rob.cdb_rob_num];
  assign do_commit_s   = normal_s && busy_q[head_q] && ready_q[head_q];
  assign mispredict_s  = do_commit_s && is_br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

  // Entry payload capture at allocation and on CDB broadcast.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_br_q <= VEC_ZERO;
      pred_q  <= VEC_ZERO;
      taken_q <= VEC_ZERO;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rd_q[i]     <= REG_ZERO;
        data_q[i]   <= DATA_ZERO;
        target_q[i] <= DATA_ZERO;
      end
    end else if (rdy) begin
      if (do_alloc_s) begin
        rd_q[tail_q]    <= rob.alloc_rd;
        is_br_q[tail_q] <= rob.alloc_is_branch;
        pred_q[tail_q]  <= rob.alloc_pred_taken;
      end
      if (cdb_wr_s) begin
        data_q[rob.cdb_rob_num]   <= rob.cdb_data;
        taken_q[rob.cdb_rob_num]  <= rob.cdb_taken;
        target_q[rob.cdb_rob_num] <= rob.cdb_target;
      end
    end
  end

  // Next-state for entry flags, pointers, FSM and the registered commit port.
  always_comb begin
    busy_d           = busy_q;
    ready_d          = ready_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    state_d          = state_q;
    has_from_rob_d   = 1'b0;
    dest_reg_num_d   = dest_reg_num_q;
    in_reg_data_d    = in_reg_data_q;
    in_reg_rob_num_d = in_reg_rob_num_q;
    has_misbranch_d  = 1'b0;
    misbranch_pc_d   = misbranch_pc_q;
    case (state_q)
      ST_NORMAL: begin
        if (cdb_wr_s) begin
          ready_d[rob.cdb_rob_num] = 1'b1;
        end else begin
          ready_d = ready_q;
        end
        if (do_alloc_s) begin
          busy_d[tail_q]  = 1'b1;
          ready_d[tail_q] = 1'b0;
          tail_d          = tail_q + PTR_ONE;
        end else begin
          tail_d = tail_q;
        end
        // Commit uses the head's ready bit as stored before this edge.
        if (do_commit_s) begin
          has_from_rob_d   = 1'b1;
          dest_reg_num_d   = rd_q[head_q];
          in_reg_data_d    = data_q[head_q];
          in_reg_rob_num_d = head_q;
          busy_d[head_q]   = 1'b0;
          ready_d[head_q]  = 1'b0;
          head_d           = head_q + PTR_ONE;
        end else begin
          has_from_rob_d = 1'b0;
        end
        if (mispredict_s) begin
          misbranch_pc_d = target_q[head_q];
          state_d        = ST_FLUSH;
        end else begin
          state_d = ST_NORMAL;
        end
        if (do_alloc_s && !do_commit_s) begin
          count_d = count_q + CNT_ONE;
        end else if (!do_alloc_s && do_commit_s) begin
          count_d = count_q - CNT_ONE;
        end else begin
          count_d = count_q;
        end
      end
      ST_FLUSH: begin
        busy_d          = VEC_ZERO;
        ready_d         = VEC_ZERO;
        head_d          = PTR_ZERO;
        tail_d          = PTR_ZERO;
        count_d         = CNT_ZERO;
        has_misbranch_d = 1'b1;
        state_d         = ST_NORMAL;
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  // State and registered outputs; everything holds while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q           <= VEC_ZERO;
      ready_q          <= VEC_ZERO;
      head_q           <= PTR_ZERO;
      tail_q           <= PTR_ZERO;
      count_q          <= CNT_ZERO;
      state_q          <= ST_NORMAL;
      has_from_rob_q   <= 1'b0;
      dest_reg_num_q   <= REG_ZERO;
      in_reg_data_q    <= DATA_ZERO;
      in_reg_rob_num_q <= PTR_ZERO;
      has_misbranch_q  <= 1'b0;
      misbranch_pc_q   <= DATA_ZERO;
    end else if (rdy) begin
      busy_q           <= busy_d;
      ready_q          <= ready_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      state_q          <= state_d;
      has_from_rob_q   <= has_from_rob_d;
      dest_reg_num_q   <= dest_reg_num_d;
      in_reg_data_q    <= in_reg_data_d;
      in_reg_rob_num_q <= in_reg_rob_num_d;
      has_misbranch_q  <= has_misbranch_d;
      misbranch_pc_q   <= misbranch_pc_d;
    end
  end

  // Operand lookups, with same-cycle forwarding from the CDB.
  always_comb begin
    if (rob.cdb_valid && (rob.cdb_rob_num == rob.q1_rob_num)) begin
      q1_ready_s = 1'b1;
      q1_data_s  = rob.cdb_data;
    end else begin
      q1_ready_s = ready_q[rob.q1_rob_num];
      q1_data_s  = data_q[rob.q1_rob_num];
    end
    if (rob.cdb_valid && (rob.cdb_rob_num == rob.q2_rob_num)) begin
      q2_ready_s = 1'b1;
      q2_data_s  = rob.cdb_data;
    end else begin
      q2_ready_s = ready_q[rob.q2_rob_num];
      q2_data_s  = data_q[rob.q2_rob_num];
    end
  end

  assign rob.alloc_ready    = alloc_ready_s;
  assign rob.alloc_rob_num  = tail_q;
  assign rob.rob_empty      = (count_q == CNT_ZERO);
  assign rob.q1_ready       = q1_ready_s;
  assign rob.q1_data        = q1_data_s;
  assign rob.q2_ready       = q2_ready_s;
  assign rob.q2_data        = q2_data_s;
  assign rob.has_from_rob   = has_from_rob_q;
  assign rob.dest_reg_num   = dest_reg_num_q;
  assign rob.in_reg_data    = in_reg_data_q;
  assign rob.in_reg_rob_num = in_reg_rob_num_q;
  assign rob.has_misbranch  = has_misbranch_q;
  assign rob.misbranch_pc   = misbranch_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench: a queue-based program-order model predicts commits and flushes,
// a separate monitor checks what the ROB presents.
module tb_reorder_buffer;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  logic rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_ADDR_W(4), .XLEN(32), .REG_ADDR_W(5)) bus ();

  reorder_buffer #(.ROB_DEPTH(16), .ROB_ADDR_W(4), .XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob(bus)
  );

  typedef struct {
    logic [3:0] tag; logic [4:0] rd; logic is_br; logic pred; logic done;
    logic [31:0] data; logic taken; logic [31:0] target;
  } ent_t;
  typedef struct { int edge_no; logic [4:0] rd; logic [31:0] data; logic [3:0] tag; } cexp_t;
  typedef struct { int edge_no; logic [31:0] pc; } mexp_t;

  ent_t  mq[$];
  cexp_t cq[$];
  mexp_t mbq[$];
  logic        m_flush;
  logic [3:0]  m_tail;
  logic [31:0] m_pc;
  int drv_edge = 0, mon_edge = 0, n_checks = 0, n_fail = 0;
  bit mon_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete(); cq.delete(); mbq.delete();
    m_flush = 1'b0; m_tail = 4'd0; m_pc = 32'd0;
  endtask

  function automatic void q_model(input logic [3:0] tag, output logic r, output logic [31:0] d);
    r = 1'b0; d = 32'd0;
    if (bus.cdb_valid && bus.cdb_rob_num == tag) begin
      r = 1'b1; d = bus.cdb_data;
    end else begin
      foreach (mq[i]) if (mq[i].tag == tag && mq[i].done) begin r = 1'b1; d = mq[i].data; end
    end
  endfunction

  // One clock edge of the reference: program-order queue, oldest completed entry retires.
  task automatic model_edge();
    ent_t e;
    bit com, al;
    drv_edge++;
    if (m_flush) begin
      mbq.push_back('{edge_no: drv_edge, pc: m_pc});
      mq.delete(); m_tail = 4'd0; m_flush = 1'b0;
    end else begin
      com = (mq.size() > 0) && mq[0].done;
      al  = bus.alloc_valid && (mq.size() < DEPTH);
      if (com) e = mq.pop_front();
      if (bus.cdb_valid)
        foreach (mq[i]) if (mq[i].tag == bus.cdb_rob_num) begin
          mq[i].done = 1'b1; mq[i].data = bus.cdb_data;
          mq[i].taken = bus.cdb_taken; mq[i].target = bus.cdb_target;
        end
      if (com) begin
        cq.push_back('{edge_no: drv_edge, rd: e.rd, data: e.data, tag: e.tag});
        if (e.is_br && (e.taken != e.pred)) begin m_flush = 1'b1; m_pc = e.target; end
      end
      if (al) begin
        mq.push_back('{tag: m_tail, rd: bus.alloc_rd, is_br: bus.alloc_is_branch,
                       pred: bus.alloc_pred_taken, done: 1'b0, data: 32'd0, taken: 1'b0, target: 32'd0});
        m_tail = m_tail + 4'd1;
      end
    end
  endtask

  task automatic check_comb();
    logic r; logic [31:0] d;
    chk("alloc_ready", bus.alloc_ready, (!m_flush && mq.size() < DEPTH));
    chk("alloc_rob_num", bus.alloc_rob_num, m_tail);
    chk("rob_empty", bus.rob_empty, (mq.size() == 0));
    q_model(bus.q1_rob_num, r, d);
    chk("q1_ready", bus.q1_ready, r);
    if (r) chk("q1_data", bus.q1_data, d);
    q_model(bus.q2_rob_num, r, d);
    chk("q2_ready", bus.q2_ready, r);
    if (r) chk("q2_data", bus.q2_data, d);
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0; bus.alloc_rd = 5'd0; bus.alloc_is_branch = 1'b0; bus.alloc_pred_taken = 1'b0;
    bus.q1_rob_num = 4'd0; bus.q2_rob_num = 4'd0;
    bus.cdb_valid = 1'b0; bus.cdb_rob_num = 4'd0; bus.cdb_data = 32'd0;
    bus.cdb_taken = 1'b0; bus.cdb_target = 32'd0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic br, input logic pred);
    bus.alloc_valid = 1'b1; bus.alloc_rd = rd; bus.alloc_is_branch = br; bus.alloc_pred_taken = pred;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data, input logic tk, input logic [31:0] tgt);
    bus.cdb_valid = 1'b1; bus.cdb_rob_num = tag; bus.cdb_data = data; bus.cdb_taken = tk; bus.cdb_target = tgt;
  endtask

  // Inputs are applied at the falling edge; the model steps just before the rising edge.
  task automatic cycle();
    #1;
    check_comb();
    if (rdy) model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int budget = 300;
    while ((mq.size() > 0 || m_flush) && budget > 0) begin
      idle(); rdy = 1'b1;
      for (int i = 0; i < mq.size(); i++)
        if (!mq[i].done) begin cdb(mq[i].tag, $urandom, mq[i].pred, $urandom); break; end
      cycle();
      budget--;
    end
    chk("drain_left", mq.size(), 0);
    idle(); cycle(); cycle();
  endtask

  task automatic rand_cycle();
    int pend[$];
    int idx;
    idle();
    rdy = ($urandom_range(0, 7) != 0);
    if ($urandom_range(0, 2) != 0)
      alloc(5'($urandom_range(0, 31)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    foreach (mq[i]) if (!mq[i].done) pend.push_back(i);
    if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
      idx = pend[$urandom_range(0, pend.size() - 1)];
      cdb(mq[idx].tag, $urandom, 1'($urandom_range(0, 1)), $urandom);
    end else if ($urandom_range(0, 7) == 0) begin
      cdb(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), $urandom);
    end
    bus.q1_rob_num = 4'($urandom_range(0, 15));
    bus.q2_rob_num = 4'($urandom_range(0, 15));
    cycle();
  endtask

  // Monitor: pops the scoreboard whenever a commit or flush strobe appears.
  initial begin : monitor
    logic r, live, p_hfr, p_hmb;
    logic [31:0] p_data, p_pc;
    cexp_t c;
    mexp_t m;
    p_hfr = 1'b0; p_hmb = 1'b0; p_data = 32'd0; p_pc = 32'd0;
    forever begin
      @(posedge clk);
      r = rdy; live = rst;
      #1;
      if (live && mon_en) begin
        if (r) begin
          mon_edge++;
          if (bus.has_from_rob) begin
            if (cq.size() == 0) chk("commit_unexpected", bus.has_from_rob, 0);
            else begin
              c = cq.pop_front();
              chk("commit_edge", mon_edge, c.edge_no);
              chk("commit_rd", bus.dest_reg_num, c.rd);
              chk("commit_data", bus.in_reg_data, c.data);
              chk("commit_tag", bus.in_reg_rob_num, c.tag);
            end
          end else if (cq.size() > 0 && cq[0].edge_no <= mon_edge) begin
            chk("commit_missing", bus.has_from_rob, 1);
            void'(cq.pop_front());
          end
          if (bus.has_misbranch) begin
            if (mbq.size() == 0) chk("flush_unexpected", bus.has_misbranch, 0);
            else begin
              m = mbq.pop_front();
              chk("flush_edge", mon_edge, m.edge_no);
              chk("misbranch_pc", bus.misbranch_pc, m.pc);
            end
          end else if (mbq.size() > 0 && mbq[0].edge_no <= mon_edge) begin
            chk("flush_missing", bus.has_misbranch, 1);
            void'(mbq.pop_front());
          end
        end else begin
          chk("hold_has_from_rob", bus.has_from_rob, p_hfr);
          chk("hold_in_reg_data", bus.in_reg_data, p_data);
          chk("hold_has_misbranch", bus.has_misbranch, p_hmb);
          chk("hold_misbranch_pc", bus.misbranch_pc, p_pc);
        end
      end
      p_hfr = bus.has_from_rob; p_data = bus.in_reg_data;
      p_hmb = bus.has_misbranch; p_pc = bus.misbranch_pc;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [3:0] base, first_tag, jal_tag;
    idle(); rdy = 1'b1; rst = 1'b1; model_reset();
    #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_alloc_ready", bus.alloc_ready, 1);
    chk("rst_alloc_rob_num", bus.alloc_rob_num, 0);
    chk("rst_rob_empty", bus.rob_empty, 1);
    chk("rst_has_from_rob", bus.has_from_rob, 0);
    chk("rst_dest_reg_num", bus.dest_reg_num, 0);
    chk("rst_in_reg_data", bus.in_reg_data, 0);
    chk("rst_in_reg_rob_num", bus.in_reg_rob_num, 0);
    chk("rst_has_misbranch", bus.has_misbranch, 0);
    chk("rst_misbranch_pc", bus.misbranch_pc, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single instruction: commit two edges after the CDB, one cycle long.
    idle(); alloc(5'd5, 1'b0, 1'b0); cycle();
    idle(); cdb(4'd0, 32'h1234, 1'b0, 32'd0); cycle();
    idle(); cycle();
    chk("t1_has_from_rob", bus.has_from_rob, 1);
    chk("t1_dest_reg_num", bus.dest_reg_num, 5);
    chk("t1_in_reg_data", bus.in_reg_data, 32'h1234);
    chk("t1_in_reg_rob_num", bus.in_reg_rob_num, 0);
    cycle();
    chk("t1_strobe_low", bus.has_from_rob, 0);
    chk("t1_rob_empty", bus.rob_empty, 1);

    // Out-of-order completion, in-order retirement.
    base = m_tail;
    idle(); alloc(5'd1, 1'b0, 1'b0); cycle();
    idle(); alloc(5'd2, 1'b0, 1'b0); cycle();
    idle(); alloc(5'd3, 1'b0, 1'b0); cycle();
    idle(); cdb(base + 4'd2, 32'hC2, 1'b0, 32'd0); cycle();
    idle(); cdb(base, 32'hC0, 1'b0, 32'd0); cycle();
    idle(); cdb(base + 4'd1, 32'hC1, 1'b0, 32'd0); cycle();
    idle(); repeat (4) cycle();

    // Fill to capacity; a same-edge commit must not let an allocation in.
    drain();
    first_tag = m_tail;
    for (int i = 0; i < DEPTH; i++) begin idle(); alloc(5'($urandom_range(1, 31)), 1'b0, 1'b0); cycle(); end
    chk("full_alloc_ready", bus.alloc_ready, 0);
    idle(); alloc(5'd9, 1'b0, 1'b0); cdb(first_tag, 32'hF00D, 1'b0, 32'd0); cycle();
    idle(); alloc(5'd9, 1'b0, 1'b0); cycle();
    chk("full_commit_tag", bus.in_reg_rob_num, first_tag);
    chk("full_reissue_tag", bus.alloc_rob_num, first_tag);
    idle(); alloc(5'd9, 1'b0, 1'b0); cycle();
    drain();

    // Mispredicted jalr: link write first, then the flush pulse.
    jal_tag = m_tail;
    idle(); alloc(5'd1, 1'b1, 1'b0); cycle();
    idle(); alloc(5'd7, 1'b0, 1'b0); cycle();
    idle(); alloc(5'd8, 1'b0, 1'b0); cdb(jal_tag, 32'h48, 1'b1, 32'h100); cycle();
    idle(); cycle();
    chk("mis_has_from_rob", bus.has_from_rob, 1);
    chk("mis_dest_reg_num", bus.dest_reg_num, 1);
    chk("mis_in_reg_data", bus.in_reg_data, 32'h48);
    chk("mis_alloc_ready_flush", bus.alloc_ready, 0);
    cycle();
    chk("mis_has_misbranch", bus.has_misbranch, 1);
    chk("mis_misbranch_pc", bus.misbranch_pc, 32'h100);
    chk("mis_strobe_low", bus.has_from_rob, 0);
    chk("mis_rob_empty", bus.rob_empty, 1);
    chk("mis_alloc_rob_num", bus.alloc_rob_num, 0);
    cycle();
    chk("mis_pulse_end", bus.has_misbranch, 0);

    // Same-cycle CDB forwarding on an operand lookup.
    idle(); bus.q1_rob_num = 4'd3; cdb(4'd3, 32'hAB, 1'b0, 32'd0);
    #1;
    chk("byp_q1_ready", bus.q1_ready, 1);
    chk("byp_q1_data", bus.q1_data, 32'hAB);
    cycle();

    // Stall with a commit strobe pending: it is held and nothing else retires.
    drain();
    base = m_tail;
    idle(); alloc(5'd10, 1'b0, 1'b0); cycle();
    idle(); alloc(5'd11, 1'b0, 1'b0); cdb(base, 32'hA0, 1'b0, 32'd0); cycle();
    idle(); cdb(base + 4'd1, 32'hA1, 1'b0, 32'd0); cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      rdy = 1'b0; cycle();
      chk("stall_strobe", bus.has_from_rob, 1);
      chk("stall_tag", bus.in_reg_rob_num, base);
    end
    rdy = 1'b1; cycle();
    chk("stall_next_tag", bus.in_reg_rob_num, base + 4'd1);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) rand_cycle();
    drain();
    chk("commits_outstanding", cq.size(), 0);
    chk("flushes_outstanding", mbq.size(), 0);

    // Reset during the flush cycle aborts the flush.
    mon_en = 1'b0;
    idle(); alloc(5'd0, 1'b1, 1'b0); cycle();
    idle(); cdb(m_tail - 4'd1, 32'd0, 1'b1, 32'h200); cycle();
    idle(); cycle();
    #2 rst = 1'b0;
    #1;
    chk("rstf_has_misbranch", bus.has_misbranch, 0);
    chk("rstf_has_from_rob", bus.has_from_rob, 0);
    chk("rstf_rob_empty", bus.rob_empty, 1);
    chk("rstf_alloc_ready", bus.alloc_ready, 1);
    @(negedge clk);
    rst = 1'b1; model_reset();
    idle(); cycle();
    chk("rstf_no_pulse", bus.has_misbranch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
